irq_ctrl: RTL and testbench

Programmable interrupt controller between the microsystem's six device interrupt lines and the CP0 HWInt input. It latches device requests as edge- or level-sensitive, masks them, and presents only the single highest-priority enabled request to CP0. It then holds off further requests until the handler signals end-of-interrupt. Configuration and status are exposed as a four-word slave on the bridge.

---
 rtl/irq_ctrl_pkg.sv | 20 ++
 rtl/irq_ctrl_if.sv | 14 +
 rtl/irq_ctrl_prio_enc6.sv | 27 ++
 rtl/irq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared definitions for the interrupt controller.
//   NSRC        number of device interrupt sources (maps onto HWInt[7:2])
//   REG_*       word offsets of the four bridge-visible registers
//   state_t     controller state encoding
package irq_ctrl_pkg;

  localparam int NSRC = 6;

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_MODE    = 2'd1;
  localparam logic [1:0] REG_PENDING = 2'd2;
  localparam logic [1:0] REG_INSVC   = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: four-word register slave port on the bridge.
//   addr   word select (bridge address bits [3:2])
//   we     write strobe
//   wdata  write data
//   rdata  read data, combinational from addr
interface irq_ctrl_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/irq_ctrl_prio_enc6.sv
// prio_enc6: fixed-priority encoder, lowest index wins.
//   req     6-bit request vector
//   any     at least one request bit set
//   id      index of the winning request (0 when none)
//   onehot  one-hot of the winning request (0 when none)
module prio_enc6 (
  input  logic [5:0] req,
  output logic       any,
  output logic [2:0] id,
  output logic [5:0] onehot
);

  // Pick the lowest set bit of req.
  always_comb begin
    any = |req;
    casez (req)
      6'b?????1: begin id = 3'd0; onehot = 6'b000001; end
      6'b????10: begin id = 3'd1; onehot = 6'b000010; end
      6'b???100: begin id = 3'd2; onehot = 6'b000100; end
      6'b??1000: begin id = 3'd3; onehot = 6'b001000; end
      6'b?10000: begin id = 3'd4; onehot = 6'b010000; end
      6'b100000: begin id = 3'd5; onehot = 6'b100000; end
      default:   begin id = 3'd0; onehot = 6'b000000; end
    endcase
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: programmable interrupt controller in front of CP0 HWInt[7:2].
//   clk, reset  system clock, synchronous active-high reset
//   irq_src     raw device lines, bit 0 highest priority
//   bus         register slave (ENABLE, MODE, PENDING w1c, INSVC / EOI)
//   int_taken   CP0 commits to the presented interrupt
//   hwint       one-hot of the highest enabled pending request, only in REQ
//   busy        an interrupt is in service (awaiting EOI)
module irq_ctrl
  import irq_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  irq_ctrl_if.slave       bus,
  input  logic            int_taken,
  output logic [NSRC-1:0] hwint,
  output logic            busy
);

  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] pending_next;
  logic [NSRC-1:0] prev;
  logic            insvc_valid;
  logic [2:0]      insvc_id;
  state_t          state;
  state_t          state_next;

  logic [NSRC-1:0] req;
  logic            sel_any;
  logic [2:0]      sel_id;
  logic [NSRC-1:0] sel_onehot;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] take_clr;
  logic            taken;
  logic            eoi;

  assign req = pending & enable;

  prio_enc6 u_prio (
    .req    (req),
    .any    (sel_any),
    .id     (sel_id),
    .onehot (sel_onehot)
  );

  // int_taken only counts while a request is actually being presented.
  assign taken = int_taken && (state == REQ) && sel_any;
  assign eoi   = bus.we && (bus.addr == REG_INSVC) && (state == SERVICE);

  // Clear masks from a PENDING write and from accepting the current request.
  always_comb begin
    if (bus.we && (bus.addr == REG_PENDING)) begin
      w1c = bus.wdata[NSRC-1:0];
    end else begin
      w1c = {NSRC{1'b0}};
    end
    if (taken) begin
      take_clr = sel_onehot;
    end else begin
      take_clr = {NSRC{1'b0}};
    end
  end

  // Edge bits: sticky, cleared by W1C or acceptance, a new edge always wins.
  // Level bits: simply track the sampled line.
  assign pending_next = (mode & ((pending & ~w1c & ~take_clr) | (irq_src & ~prev)))
                      | (~mode & irq_src);

  // Configuration, pending, edge history and in-service registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable      <= {NSRC{1'b0}};
      mode        <= {NSRC{1'b0}};
      pending     <= {NSRC{1'b0}};
      prev        <= {NSRC{1'b0}};
      insvc_valid <= 1'b0;
      insvc_id    <= 3'd0;
    end else begin
      prev    <= irq_src;
      pending <= pending_next;
      if (bus.we && (bus.addr == REG_ENABLE)) begin
        enable <= bus.wdata[NSRC-1:0];
      end
      if (bus.we && (bus.addr == REG_MODE)) begin
        mode <= bus.wdata[NSRC-1:0];
      end
      if (taken) begin
        insvc_valid <= 1'b1;
        insvc_id    <= sel_id;
      end else if (eoi) begin
        insvc_valid <= 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (sel_any) begin
          state_next = REQ;
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        if (!sel_any) begin
          state_next = IDLE;
        end else if (taken) begin
          state_next = SERVICE;
        end else begin
          state_next = REQ;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_next = IDLE;
        end else begin
          state_next = SERVICE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: hwint tracks the encoder while in REQ, busy marks SERVICE.
  always_comb begin
    hwint = {NSRC{1'b0}};
    busy  = 1'b0;
    case (state)
      REQ:     hwint = sel_onehot;
      SERVICE: busy  = 1'b1;
      default: begin
        hwint = {NSRC{1'b0}};
        busy  = 1'b0;
      end
    endcase
  end

  // Register read mux; unused bits read 0.
  always_comb begin
    case (bus.addr)
      REG_ENABLE:  bus.rdata = {26'd0, enable};
      REG_MODE:    bus.rdata = {26'd0, mode};
      REG_PENDING: bus.rdata = {26'd0, pending};
      REG_INSVC:   bus.rdata = {insvc_valid, 28'd0, insvc_id};
      default:     bus.rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized traffic against a
// behavioural model of the interrupt controller.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       int_taken;
  logic [5:0] irq_src;
  logic [5:0] hwint;
  logic       busy;

  irq_ctrl_if bus ();

  irq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .bus       (bus),
    .int_taken (int_taken),
    .hwint     (hwint),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 = waiting, 1 = presenting a request, 2 = handler running.
  logic [5:0] m_en, m_mode, m_pend, m_prev;
  int         m_phase;
  int         m_id;
  bit         m_valid;

  function automatic int lowest(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int         s;
    logic [5:0] np;
    bit         acc;
    if (reset) begin
      m_en = 6'd0; m_mode = 6'd0; m_pend = 6'd0; m_prev = 6'd0;
      m_phase = 0; m_id = 0; m_valid = 1'b0;
    end else begin
      s   = lowest(m_pend & m_en);
      acc = (m_phase == 1) && (s >= 0) && int_taken;
      for (int i = 0; i < 6; i++) begin
        if (m_mode[i]) begin
          np[i] = m_pend[i];
          if (bus.we && bus.addr == 2'd2 && bus.wdata[i]) np[i] = 1'b0;
          if (acc && i == s) np[i] = 1'b0;
          if (irq_src[i] && !m_prev[i]) np[i] = 1'b1;
        end else begin
          np[i] = irq_src[i];
        end
      end
      case (m_phase)
        0: if (s >= 0) m_phase = 1;
        1: if (s < 0) m_phase = 0;
           else if (acc) begin m_phase = 2; m_id = s; m_valid = 1'b1; end
        default: if (bus.we && bus.addr == 2'd3) begin m_phase = 0; m_valid = 1'b0; end
      endcase
      if (bus.we && bus.addr == 2'd0) m_en = bus.wdata[5:0];
      if (bus.we && bus.addr == 2'd1) m_mode = bus.wdata[5:0];
      m_pend = np;
      m_prev = irq_src;
    end
  endtask

  function automatic logic [5:0] exp_hwint();
    int s = lowest(m_pend & m_en);
    if (m_phase == 1 && s >= 0) return 6'd1 << s;
    return 6'd0;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return {26'd0, m_en};
      2'd1:    return {26'd0, m_mode};
      2'd2:    return {26'd0, m_pend};
      default: return {m_valid, 28'd0, 3'(m_id)};
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    bus.addr = a; bus.we = 1'b1; bus.wdata = d;
    cycle();
    bus.we = 1'b0; bus.wdata = 32'd0;
  endtask

  task automatic take();
    int_taken = 1'b1;
    cycle();
    int_taken = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_src = 6'd0; int_taken = 1'b0;
    bus.addr = 2'd0; bus.we = 1'b0; bus.wdata = 32'd0;
    cycle(); cycle();
    reset = 1'b0;
    n_checks++; if (hwint !== 6'd0) begin n_fail++; $display("FAIL reset_hwint: got %h expected 00", hwint); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    for (int a = 0; a < 4; a++) begin
      bus.addr = 2'(a); #1;
      n_checks++; if (bus.rdata !== 32'd0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 0", a, bus.rdata); end
    end
  endtask

  task automatic test_level();
    write_reg(2'd0, 32'h3F);
    write_reg(2'd1, 32'h00);
    irq_src = 6'h04;
    cycle();
    n_checks++; if (hwint !== 6'h00) begin n_fail++; $display("FAIL level_t1: got %h expected 00", hwint); end
    cycle();
    n_checks++; if (hwint !== 6'h04) begin n_fail++; $display("FAIL level_t2: got %h expected 04", hwint); end
    bus.addr = 2'd2; #1;
    n_checks++; if (bus.rdata !== 32'h04) begin n_fail++; $display("FAIL level_pending: got %h expected 04", bus.rdata); end
    take();
    n_checks++; if (busy !== 1'b1 || hwint !== 6'h00) begin n_fail++; $display("FAIL level_taken: got busy=%b hwint=%h expected 1/00", busy, hwint); end
    bus.addr = 2'd3; #1;
    n_checks++; if (bus.rdata !== 32'h80000002) begin n_fail++; $display("FAIL level_insvc: got %h expected 80000002", bus.rdata); end
    irq_src = 6'h00;
    write_reg(2'd3, 32'd0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL level_eoi: got busy=%b expected 0", busy); end
    cycle();
  endtask

  task automatic test_edge_eoi();
    write_reg(2'd1, 32'h3F);
    irq_src = 6'h20; cycle();
    irq_src = 6'h00; cycle();
    n_checks++; if (hwint !== 6'h20) begin n_fail++; $display("FAIL edge_hwint: got %h expected 20", hwint); end
    bus.addr = 2'd2; #1;
    n_checks++; if (bus.rdata !== 32'h20) begin n_fail++; $display("FAIL edge_pending: got %h expected 20", bus.rdata); end
    take();
    bus.addr = 2'd2; #1;
    n_checks++; if (bus.rdata !== 32'h00 || busy !== 1'b1) begin n_fail++; $display("FAIL edge_taken: got pending=%h busy=%b expected 0/1", bus.rdata, busy); end
    write_reg(2'd3, 32'd0);
    cycle();
    n_checks++; if (busy !== 1'b0 || hwint !== 6'h00) begin n_fail++; $display("FAIL edge_eoi: got busy=%b hwint=%h expected 0/00", busy, hwint); end
  endtask

  task automatic test_priority();
    irq_src = 6'h0A; cycle();
    irq_src = 6'h00; cycle();
    n_checks++; if (hwint !== 6'h02) begin n_fail++; $display("FAIL prio_first: got %h expected 02", hwint); end
    take();
    write_reg(2'd3, 32'd0);
    cycle();
    n_checks++; if (hwint !== 6'h08) begin n_fail++; $display("FAIL prio_second: got %h expected 08", hwint); end
    take();
    write_reg(2'd3, 32'd0);
  endtask

  task automatic test_masking();
    write_reg(2'd0, 32'h00);
    irq_src = 6'h01; cycle();
    irq_src = 6'h00; cycle();
    bus.addr = 2'd2; #1;
    n_checks++; if (bus.rdata !== 32'h01 || hwint !== 6'h00) begin n_fail++; $display("FAIL mask_hold: got pending=%h hwint=%h expected 01/00", bus.rdata, hwint); end
    write_reg(2'd0, 32'h01);
    cycle();
    n_checks++; if (hwint !== 6'h01) begin n_fail++; $display("FAIL mask_unmask: got %h expected 01", hwint); end
    write_reg(2'd2, 32'h01);
    cycle();
    write_reg(2'd0, 32'h3F);
  endtask

  task automatic test_simultaneous();
    irq_src = 6'h04; cycle();
    irq_src = 6'h00; cycle();
    irq_src = 6'h04;
    write_reg(2'd2, 32'h04);
    bus.addr = 2'd2; #1;
    n_checks++; if (bus.rdata[2] !== 1'b1) begin n_fail++; $display("FAIL simul_w1c_edge: got %b expected 1", bus.rdata[2]); end
    bus.addr = 2'd2; bus.we = 1'b1; bus.wdata = 32'h04; int_taken = 1'b1;
    cycle();
    bus.we = 1'b0; bus.wdata = 32'd0; int_taken = 1'b0;
    bus.addr = 2'd3; #1;
    n_checks++; if (bus.rdata !== 32'h80000002 || busy !== 1'b1) begin n_fail++; $display("FAIL simul_take_w1c: got insvc=%h busy=%b expected 80000002/1", bus.rdata, busy); end
    irq_src = 6'h10;
    write_reg(2'd3, 32'd0);
    cycle();
    n_checks++; if (hwint !== 6'h10) begin n_fail++; $display("FAIL simul_eoi_edge: got %h expected 10", hwint); end
    irq_src = 6'h00;
    take();
    write_reg(2'd3, 32'd0);
  endtask

  task automatic test_reset_midservice();
    irq_src = 6'h02; cycle();
    irq_src = 6'h00; cycle();
    take();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midsvc_enter: got busy=%b expected 1", busy); end
    reset = 1'b1; cycle(); reset = 1'b0;
    n_checks++; if (busy !== 1'b0 || hwint !== 6'h00) begin n_fail++; $display("FAIL midsvc_out: got busy=%b hwint=%h expected 0/00", busy, hwint); end
    for (int a = 0; a < 4; a++) begin
      bus.addr = 2'(a); #1;
      n_checks++; if (bus.rdata !== 32'd0) begin n_fail++; $display("FAIL midsvc_reg%0d: got %h expected 0", a, bus.rdata); end
    end
  endtask

  task automatic test_random();
    logic [1:0] ra;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ (6'($urandom) & 6'($urandom));
      bus.we    = ($urandom_range(0, 5) == 0);
      bus.addr  = 2'($urandom);
      bus.wdata = $urandom;
      if (bus.we && bus.addr == 2'd0 && $urandom_range(0, 1) == 0) bus.wdata = 32'h3F;
      int_taken = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      cycle();
      bus.we = 1'b0; int_taken = 1'b0; reset = 1'b0;
      n_checks++; if (hwint !== exp_hwint()) begin n_fail++; $display("FAIL rand_hwint@%0d: got %h expected %h", n, hwint, exp_hwint()); end
      n_checks++; if (busy !== (m_phase == 2)) begin n_fail++; $display("FAIL rand_busy@%0d: got %b expected %b", n, busy, (m_phase == 2)); end
      ra = 2'($urandom); bus.addr = ra; #1;
      n_checks++; if (bus.rdata !== exp_rdata(ra)) begin n_fail++; $display("FAIL rand_rdata%0d@%0d: got %h expected %h", ra, n, bus.rdata, exp_rdata(ra)); end
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge_eoi();
    test_priority();
    test_masking();
    test_simultaneous();
    test_reset_midservice();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
